nest_checker: RTL

//   Streaming begin/end nesting checker: the parametrised successor to the character-stream block checker.
//   - Input: one 8-bit ASCII character per clock.
//   - Recognises the words "begin" and "end" and tracks nesting depth up to a configurable maximum.
//   - Reports balance, current depth, and a sticky error for unmatched "end" or depth overflow.
//   - Sits after the text-stream source and feeds status logic.

---
 rtl/nest_checker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/nest_checker.sv
// nest_checker: streaming begin/end nesting checker.
//
// The block takes one ASCII character per clock and splits the stream into words on the space
// character (8'h20). It recognises the words "begin" and "end" and tracks the nesting depth, which
// saturates at MAX_DEPTH. A recognised word is counted tentatively on the edge that samples its
// final letter. It is committed if the next character is a space, and reverted if the next
// character extends the word (for example "beginx" or "ends").
//
// Configuration macro:
//   NEST_CHECKER_CASE_SENS_EN  defined: only lowercase "begin"/"end" match.
//                              undefined (default): matching ignores case.
//
// Parameters:
//   CNT_W      depth counter width in bits
//   MAX_DEPTH  largest legal depth (1 .. 2**CNT_W-1)
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   in      ASCII character, sampled on every rising edge
//   result  1 when balanced: depth==0, no pending underflow, err==0
//   depth   current nesting depth, including a tentative count
//   err     sticky error: a committed unmatched "end" or a committed depth overflow
module nest_checker #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_DEPTH = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  output logic             result,
  output logic [CNT_W-1:0] depth,
  output logic             err
);

  localparam logic [CNT_W-1:0] MaxDepth = CNT_W'(MAX_DEPTH);

  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChB     = 8'h62;
  localparam logic [7:0] ChD     = 8'h64;
  localparam logic [7:0] ChE     = 8'h65;
  localparam logic [7:0] ChG     = 8'h67;
  localparam logic [7:0] ChI     = 8'h69;
  localparam logic [7:0] ChN     = 8'h6e;

  typedef enum logic [3:0] {
    StSep, StB, StBe, StBeg, StBegi, StBegin, StE, StEn, StEnd, StOther
  } state_e;

  // Which side effect the tentative word has when it is committed. This is non-none only in
  // StBegin/StEnd.
  typedef enum logic [1:0] {PendNone, PendOvf, PendUnf} pend_e;

  state_e           state_q, state_d;
  pend_e            pend_q, pend_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             err_q, err_d;
  logic [7:0]       ch;
  logic             is_space;

  // Normalise the character before matching.
  always_comb begin
    ch = in;
`ifndef NEST_CHECKER_CASE_SENS_EN
    if (in >= 8'h41 && in <= 8'h5a) begin
      ch = in | 8'h20;
    end
`endif
  end

  assign is_space = (in == ChSpace);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    depth_d = depth_q;
    err_d   = err_q;

    if (is_space) begin
      // A space commits a tentative word. Any pending error becomes sticky.
      state_d = StSep;
      if ((state_q == StBegin || state_q == StEnd) && pend_q != PendNone) begin
        err_d = 1'b1;
      end
      pend_d = PendNone;
    end else begin
      state_d = StOther;
      unique case (state_q)
        StSep: begin
          if (ch == ChB) begin
            state_d = StB;
          end else if (ch == ChE) begin
            state_d = StE;
          end
        end
        StB:    if (ch == ChE) state_d = StBe;
        StBe:   if (ch == ChG) state_d = StBeg;
        StBeg:  if (ch == ChI) state_d = StBegi;
        StBegi: begin
          if (ch == ChN) begin
            state_d = StBegin;
            if (depth_q < MaxDepth) begin
              depth_d = depth_q + 1'b1;
            end else begin
              pend_d = PendOvf;
            end
          end
        end
        StE:    if (ch == ChN) state_d = StEn;
        StEn: begin
          if (ch == ChD) begin
            state_d = StEnd;
            if (depth_q != '0) begin
              depth_d = depth_q - 1'b1;
            end else begin
              pend_d = PendUnf;
            end
          end
        end
        // The word continues past the keyword, so undo the tentative count. A saturated or
        // underflowed word never moved the counter, so there is nothing to undo for it.
        StBegin: begin
          if (pend_q == PendNone) begin
            depth_d = depth_q - 1'b1;
          end
          pend_d = PendNone;
        end
        StEnd: begin
          if (pend_q == PendNone) begin
            depth_d = depth_q + 1'b1;
          end
          pend_d = PendNone;
        end
        StOther: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StSep;
      pend_q  <= PendNone;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign depth  = depth_q;
  assign err    = err_q;
  assign result = (depth_q == '0) && (pend_q != PendUnf) && !err_q;

endmodule
